// File: rtl/seg_scan_pkg.sv
// Shared types and elaboration helpers for the display scan controller.
package seg_scan_pkg;

    // Scan phases: dark, inter-digit dead-time, digit lit.
    typedef enum logic [1:0] {StIdle, StBlank, StDrive} scan_state_e;

    localparam int unsigned MinDigits = 1;
    localparam int unsigned MaxDigits = 8;

    // Digit index width; never below one bit so a single-digit build still has a vector.
    function automatic int unsigned idx_width(int unsigned num_digits);
        return (num_digits < 2) ? 1 : $clog2(num_digits);
    endfunction

    // Legal parameter combinations for the scan controller.
    function automatic bit params_ok(int unsigned num_digits, int unsigned refresh_div,
                                     int unsigned blank_cycles);
        return (num_digits >= MinDigits) && (num_digits <= MaxDigits) &&
               (blank_cycles >= 1) && (refresh_div > blank_cycles);
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer: counts cycles within the current scan phase and flags the last
// cycle of the blank phase and of the drive phase.
module seg_scan_timer #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic blank_done,
    output logic slot_done
);

    localparam int unsigned CntW = (REFRESH_DIV < 2) ? 1 : $clog2(REFRESH_DIV);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [CntW-1:0] DriveLast = CntW'(REFRESH_DIV - BLANK_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Clear wins over counting so every phase starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign blank_done = (cnt_q == BlankLast);
    assign slot_done  = (cnt_q == DriveLast);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: multiplexes NUM_DIGITS BCD digits onto one
// shared decoder with a dark dead-time between digit slots.
// Optional feature macro: SEG_SCAN_LEADING_ZERO_BLANK_EN (leading-zero blanking).
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [3:0]              bcd_sel,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int unsigned IdxW = idx_width(NUM_DIGITS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

    if (!params_ok(NUM_DIGITS, REFRESH_DIV, BLANK_CYCLES)) begin : gen_param_check
        $error("seg_scan_ctrl: illegal NUM_DIGITS/REFRESH_DIV/BLANK_CYCLES");
    end

    scan_state_e             state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                    load_snap;
    logic                    blank_done, slot_done;
    logic                    timer_clear, timer_run;
    logic [NUM_DIGITS-1:0]   dark;

    logic [3:0]              bcd_sel_d;
    logic [NUM_DIGITS-1:0]   an_n_d;
    logic                    dp_n_d;
    logic                    frame_start_d;

    // Phase timing; the counter restarts on every state change.
    assign timer_clear = (state_d != state_q);
    assign timer_run   = (state_q != StIdle);

    seg_scan_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (timer_clear),
        .run        (timer_run),
        .blank_done (blank_done),
        .slot_done  (slot_done)
    );

    // State, digit index and frame snapshot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
        end
    end

    // Next state; disable overrides everything, including a wrap on the same edge.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        load_snap     = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d   = StBlank;
                    idx_d     = '0;
                    load_snap = 1'b1;
                end
                StBlank: begin
                    if (blank_done) begin
                        state_d = StDrive;
                    end
                end
                StDrive: begin
                    if (slot_done) begin
                        state_d = StBlank;
                        if (idx_q == LastIdx) begin
                            idx_d     = '0;
                            load_snap = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
            // Snapshot only at frame start so a frame never tears mid-scan.
            if (load_snap) begin
                snap_digits_d = digits_bcd;
                snap_dp_d     = dp_mask;
            end
        end
    end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic upper_zero;

    // A digit stays dark when it and every digit above it is zero and its DP is off.
    always_comb begin
        upper_zero = 1'b1;
        dark       = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (snap_digits_d[4*i +: 4] == 4'd0);
            dark[i]    = (i != 0) & upper_zero & ~snap_dp_d[i];
        end
    end
`else
    assign dark = '0;
`endif

    // Output next values are decoded from the next state so the ports are pure flops.
    always_comb begin
        bcd_sel_d     = '0;
        an_n_d        = '1;
        dp_n_d        = 1'b1;
        frame_start_d = load_snap;
        if (state_d != StIdle) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_d == IdxW'(i)) begin
                    bcd_sel_d = snap_digits_d[4*i +: 4];
                    if ((state_d == StDrive) && !dark[i]) begin
                        an_n_d[i] = 1'b0;
                        dp_n_d    = ~snap_dp_d[i];
                    end
                end
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_sel     <= '0;
            an_n        <= '1;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            bcd_sel     <= bcd_sel_d;
            an_n        <= an_n_d;
            dp_n        <= dp_n_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: randomized stimulus, cycle-level reference model
// derived from slot arithmetic, scoreboard queue drained by a separate monitor.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int R  = 8;
    localparam int B  = 2;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic [4*ND-1:0] digits_bcd;
    logic [ND-1:0]   dp_mask;
    logic [3:0]      bcd_sel;
    logic [ND-1:0]   an_n;
    logic            dp_n;
    logic            frame_start;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .digits_bcd  (digits_bcd),
        .dp_mask     (dp_mask),
        .bcd_sel     (bcd_sel),
        .an_n        (an_n),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    bcd;
        logic [ND-1:0] an;
        logic          dp;
        logic          fs;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: cycles since scan start, frame snapshot.
    bit            m_active = 1'b0;
    bit            m_fs     = 1'b0;
    int            m_k      = 0;
    logic [4*ND-1:0] m_digits = '0;
    logic [ND-1:0]   m_dp     = '0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic bit digit_lit(int idx);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        if (idx == 0) return 1'b1;
        for (int j = idx; j < ND; j++) begin
            if (m_digits[j*4 +: 4] != 4'd0) return 1'b1;
        end
        return m_dp[idx];
`else
        return 1'b1;
`endif
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_update();
        m_fs = 1'b0;
        if (!rst_n || !enable) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_k      = 0;
            m_digits = digits_bcd;
            m_dp     = dp_mask;
            m_fs     = 1'b1;
        end else begin
            m_k++;
            if (m_k % (ND * R) == 0) begin
                m_digits = digits_bcd;
                m_dp     = dp_mask;
                m_fs     = 1'b1;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   idx;
        int   off;
        e.bcd = 4'd0;
        e.an  = '1;
        e.dp  = 1'b1;
        e.fs  = m_fs;
        if (m_active) begin
            idx   = (m_k / R) % ND;
            off   = m_k % R;
            e.bcd = m_digits[idx*4 +: 4];
            if (off >= B && digit_lit(idx)) begin
                e.an[idx] = 1'b0;
                e.dp      = ~m_dp[idx];
            end
        end
        return e;
    endfunction

    // One clock: inputs already applied, predict the post-edge outputs.
    task automatic step();
        @(posedge clk);
        model_update();
        sb.push_back(model_out());
        @(negedge clk);
    endtask

    // Monitor: compare DUT outputs against the queued prediction on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("an_n_onehot", 32'($countones(~an_n) <= 1), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("bcd_sel", 32'(bcd_sel), 32'(e.bcd));
                check("an_n", 32'(an_n), 32'(e.an));
                check("dp_n", 32'(dp_n), 32'(e.dp));
                check("frame_start", 32'(frame_start), 32'(e.fs));
            end
        end
    end

    initial begin
        int guard;
        rst_n      = 1'b0;
        enable     = 1'b0;
        digits_bcd = '0;
        dp_mask    = '0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // First frames with a fixed pattern.
        digits_bcd = 16'h1234;
        enable     = 1'b1;
        repeat (12) step();
        // Mid-frame change must not appear until the next frame.
        digits_bcd = 16'h5678;
        repeat (40) step();
        // Decimal point on digit 2.
        dp_mask = 4'b0100;
        repeat (40) step();

        // Drop enable while digit 2 is being driven.
        guard = 0;
        while (!(((m_k / R) % ND) == 2 && (m_k % R) >= B) && guard < 100) begin
            step();
            guard++;
        end
        check("reach_idx2_drive", 32'(guard < 100), 32'd1);
        enable = 1'b0;
        repeat (3) step();
        enable = 1'b1;
        repeat (20) step();

        // Leading-zero pattern, then with DP on digit 1.
        digits_bcd = 16'h0007;
        dp_mask    = 4'b0000;
        repeat (40) step();
        dp_mask = 4'b0010;
        repeat (40) step();

        // Asynchronous reset in the middle of a drive phase.
        enable = 1'b0;
        step();
        enable = 1'b1;
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an_n", 32'(an_n), 32'hf);
        check("async_rst_bcd_sel", 32'(bcd_sel), 32'd0);
        check("async_rst_dp_n", 32'(dp_n), 32'd1);
        check("async_rst_frame_start", 32'(frame_start), 32'd0);
        m_active = 1'b0;
        m_fs     = 1'b0;
        @(negedge clk);
        repeat (2) step();
        rst_n = 1'b1;

        // Randomized traffic, biased toward leading zeros and occasional disables.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 2) == 0) digits_bcd = 16'($urandom_range(0, 15));
                else if ($urandom_range(0, 1) == 0) digits_bcd = 16'($urandom_range(0, 255));
                else digits_bcd = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
            if (enable) begin
                if ($urandom_range(0, 149) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                enable = 1'b1;
            end
            step();
        end

        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
